// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the program-memory load controller: loader states,
// memory geometry and the image-header size check.
package cpu_defs_pkg;

  localparam int PRGROM_ADDR_W = 14;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    HDR_LO  = 3'd1,
    HDR_HI  = 3'd2,
    BYTE    = 3'd3,
    WRITE   = 3'd4,
    RELEASE = 3'd5
  } ld_state_t;

  // A header may name at most one full memory (2^addr_w words).
  function automatic logic hdr_oversize(input logic [15:0] count, input int unsigned addr_w);
    return ({16'd0, count} > (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/prgmem_load_ctrl_byte_packer.sv
// Little-endian word assembler: the first byte pushed lands in bits 7:0.
// Clearing resets only the byte index, so the last assembled word stays visible.
module byte_packer
  import cpu_defs_pkg::*;
(
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic [7:0]              i_byte,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic                    o_last
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0]        r_index;
  logic [8*WORD_BYTES-1:0] r_word;

  // Byte lane write and index advance
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_index <= '0;
      r_word  <= '0;
    end else if (i_push) begin
      r_word[{r_index, 3'b000} +: 8] <= i_byte;
      r_index                        <= r_index + IDX_W'(1);
    end else if (i_clear) begin
      r_index <= '0;
    end else begin
      r_index <= r_index;
    end
  end

  assign o_word = r_word;
  assign o_last = (r_index == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/prgmem_load_ctrl.sv
// Program-memory port arbiter: forwards fetch addresses in RUN and, on request,
// writes a length-prefixed UART image word by word, then pulses the CPU reset.
module prgmem_load_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W      = PRGROM_ADDR_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_load_req,
  input  logic                    i_load_abort,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  input  logic [ADDR_W-1:0]       i_fetch_addr,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic                    o_mem_we,
  output logic [8*WORD_BYTES-1:0] o_mem_wdata,
  output logic                    o_cpu_hold,
  output logic                    o_cpu_rst,
  output logic                    o_load_busy,
  output logic                    o_load_err,
  output logic [ADDR_W:0]         o_words_loaded
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  ld_state_t r_state;
  ld_state_t w_next_state;

  logic [ADDR_W-1:0]        r_wptr;
  logic [CNT_W-1:0]         r_remaining;
  logic [CNT_W-1:0]         r_words_loaded;
  logic [7:0]               r_count_lo;
  logic                     r_load_err;
  logic [HOLD_W-1:0]        r_hold_cnt;

  logic                     w_rx_ready;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_clear;
  logic                     w_last_byte;
  logic                     w_hdr_zero;
  logic                     w_hdr_bad;
  logic [15:0]              w_count;
  logic [8*WORD_BYTES-1:0]  w_word;

  assign w_rx_ready = (r_state == HDR_LO) || (r_state == HDR_HI) || (r_state == BYTE);
  assign w_accept   = w_rx_ready && i_rx_valid;
  assign w_count    = {i_rx_data, r_count_lo};
  assign w_hdr_zero = (w_count == 16'd0);
  assign w_hdr_bad  = hdr_oversize(w_count, ADDR_W);
  // An abort wins over a byte offered in the same cycle; that byte is dropped.
  assign w_push     = (r_state == BYTE) && w_accept && !i_load_abort;
  assign w_clear    = (r_state != BYTE);

  byte_packer u_packer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_byte  (i_rx_data),
    .o_word  (w_word),
    .o_last  (w_last_byte)
  );

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN: begin
        if (i_load_req) w_next_state = HDR_LO;
        else            w_next_state = RUN;
      end
      HDR_LO: begin
        if (i_load_abort)  w_next_state = RELEASE;
        else if (w_accept) w_next_state = HDR_HI;
        else               w_next_state = HDR_LO;
      end
      HDR_HI: begin
        if (i_load_abort)                           w_next_state = RELEASE;
        else if (w_accept && (w_hdr_zero || w_hdr_bad)) w_next_state = RELEASE;
        else if (w_accept)                          w_next_state = BYTE;
        else                                        w_next_state = HDR_HI;
      end
      BYTE: begin
        if (i_load_abort)                w_next_state = RELEASE;
        else if (w_accept && w_last_byte) w_next_state = WRITE;
        else                             w_next_state = BYTE;
      end
      WRITE: begin
        if (i_load_abort || (r_remaining == CNT_W'(1))) w_next_state = RELEASE;
        else                                            w_next_state = BYTE;
      end
      RELEASE: begin
        if (r_hold_cnt == '0) w_next_state = RUN;
        else                  w_next_state = RELEASE;
      end
      default: w_next_state = RUN;
    endcase
  end

  // Load datapath: header capture, write pointer, counters and error flag
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr         <= '0;
      r_remaining    <= '0;
      r_words_loaded <= '0;
      r_count_lo     <= 8'd0;
      r_load_err     <= 1'b0;
      r_hold_cnt     <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_load_req) begin
            r_load_err     <= 1'b0;
            r_words_loaded <= '0;
            r_wptr         <= '0;
          end
        end
        HDR_LO: begin
          if (w_accept && !i_load_abort) r_count_lo <= i_rx_data;
        end
        HDR_HI: begin
          if (i_load_abort)               r_load_err  <= 1'b1;
          else if (w_accept && w_hdr_bad) r_load_err  <= 1'b1;
          else if (w_accept && !w_hdr_zero) r_remaining <= CNT_W'(w_count);
        end
        BYTE: begin
          if (i_load_abort) r_load_err <= 1'b1;
        end
        WRITE: begin
          r_wptr         <= r_wptr + ADDR_W'(1);
          r_remaining    <= r_remaining - CNT_W'(1);
          r_words_loaded <= r_words_loaded + CNT_W'(1);
          if (i_load_abort) r_load_err <= 1'b1;
        end
        default: ;
      endcase

      // Reset pulse length is set on entry and counted down to zero.
      if ((w_next_state == RELEASE) && (r_state != RELEASE)) begin
        r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
      end else if ((r_state == RELEASE) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      end
    end
  end

  assign o_rx_ready     = w_rx_ready;
  assign o_mem_addr     = (r_state == RUN) ? i_fetch_addr : r_wptr;
  assign o_mem_we       = (r_state == WRITE);
  assign o_mem_wdata    = w_word;
  assign o_cpu_hold     = (r_state != RUN);
  assign o_cpu_rst      = (r_state == RELEASE);
  assign o_load_busy    = (r_state != RUN);
  assign o_load_err     = r_load_err;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_prgmem_load_ctrl.sv
// Self-checking bench for prgmem_load_ctrl: directed scenarios plus random loads,
// with expected memory writes derived from the image format rules.
module tb_prgmem_load_ctrl;

  localparam int ADDR_W = 14;
  localparam int HOLD   = 4;
  localparam int MAXW   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic              load_abort;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_rst;
  logic              load_busy;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int checks     = 0;
  int failures   = 0;
  int rst_cycles = 0;
  int bytes_acc  = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  logic [7:0]        pay_q[$];

  always #5 clk = ~clk;

  prgmem_load_ctrl #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_load_req     (load_req),
    .i_load_abort   (load_abort),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (rx_ready),
    .i_fetch_addr   (fetch_addr),
    .o_mem_addr     (mem_addr),
    .o_mem_we       (mem_we),
    .o_mem_wdata    (mem_wdata),
    .o_cpu_hold     (cpu_hold),
    .o_cpu_rst      (cpu_rst),
    .o_load_busy    (load_busy),
    .o_load_err     (load_err),
    .o_words_loaded (words_loaded)
  );

  // Monitor memory writes, reset-pulse cycles and byte handshakes mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
    if (cpu_rst === 1'b1) rst_cycles <= rst_cycles + 1;
    if ((rx_valid === 1'b1) && (rx_ready === 1'b1)) bytes_acc <= bytes_acc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int t;
    bit done;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      step();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    done     = 1'b0;
    t        = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      done = (rx_ready === 1'b1);
      step();
      t++;
    end
    rx_valid = 1'b0;
    check("send_timeout", 32'(done), 32'd1);
  endtask

  // Waits for RUN, offering load_req throughout the reset pulse (must be ignored).
  task automatic wait_run(output int t);
    t = 0;
    while ((load_busy !== 1'b0) && t < 100) begin
      load_req = (cpu_rst === 1'b1);
      step();
      t++;
    end
    load_req = 1'b0;
    check("run_timeout", 32'(t < 100), 32'd1);
  endtask

  task automatic fill_random(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  // kind: 0 = no abort, 1 = abort after the payload (in BYTE), 2 = abort in the WRITE cycle
  task automatic run_load(input string tag, input int count, input int kind);
    int base_w, base_r, base_b, exp_words, exp_t, t, npay;
    bit hdr_ok, exp_err;
    logic [31:0] exp_data;
    base_w = wq_addr.size();
    base_r = rst_cycles;
    base_b = bytes_acc;
    npay   = pay_q.size();

    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check({tag, "_err_clr"}, 32'(load_err), 32'd0);
    check({tag, "_wl_clr"}, 32'(words_loaded), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);

    send_byte(8'(count));
    send_byte(8'(count >> 8));
    for (int i = 0; i < npay; i++) begin
      send_byte(pay_q[i]);
      if (i == 3) begin
        check({tag, "_first_we"}, 32'(mem_we), 32'd1);
        check({tag, "_first_addr"}, 32'(mem_addr), 32'd0);
      end else if (i == 0 && npay > 1 && npay != 4) begin
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        check({tag, "_req_in_byte"}, 32'(rx_ready), 32'd1);
      end
    end
    if (kind != 0) begin
      load_abort = 1'b1;
      if (kind == 2) check({tag, "_abort_we"}, 32'(mem_we), 32'd1);
      step();
      load_abort = 1'b0;
    end
    wait_run(t);

    hdr_ok    = (count != 0) && (count <= MAXW);
    exp_words = hdr_ok ? ((npay / 4 < count) ? npay / 4 : count) : 0;
    exp_err   = (count > MAXW) || (kind != 0);
    exp_t     = (hdr_ok && kind == 0) ? HOLD + 1 : HOLD;

    check({tag, "_nwrites"}, 32'(wq_addr.size() - base_w), 32'(exp_words));
    for (int k = 0; k < exp_words && (base_w + k) < wq_addr.size(); k++) begin
      exp_data = 32'(pay_q[4*k]) + 32'(pay_q[4*k+1]) * 32'd256 +
                 32'(pay_q[4*k+2]) * 32'd65536 + 32'(pay_q[4*k+3]) * 32'd16777216;
      check({tag, "_waddr"}, 32'(wq_addr[base_w + k]), 32'(k));
      check({tag, "_wdata"}, wq_data[base_w + k], exp_data);
    end
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_err"}, 32'(load_err), 32'(exp_err));
    check({tag, "_rst_len"}, 32'(rst_cycles - base_r), 32'(HOLD));
    check({tag, "_bytes"}, 32'(bytes_acc - base_b), 32'(npay + 2));
    check({tag, "_end_to_run"}, 32'(t), 32'(exp_t));
    step();
    step();
    check({tag, "_stays_run"}, 32'({cpu_hold, cpu_rst, load_busy}), 32'd0);
  endtask

  initial begin
    int base_w, base_r, base_b, cnt, kind, npay, ws;

    rst        = 1'b1;
    load_req   = 1'b0;
    load_abort = 1'b0;
    rx_data    = 8'd0;
    rx_valid   = 1'b0;
    fetch_addr = '0;
    step();
    step();
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    step();

    // Pass-through in RUN with stray rx_valid and load_abort present
    base_b     = bytes_acc;
    rx_valid   = 1'b1;
    load_abort = 1'b1;
    for (int a = 0; a < 6; a++) begin
      fetch_addr = ADDR_W'(a);
      #1;
      check("pass_addr", 32'(mem_addr), 32'(a));
      check("pass_we", 32'(mem_we), 32'd0);
      check("pass_hold", 32'(cpu_hold), 32'd0);
      check("pass_rx_ready", 32'(rx_ready), 32'd0);
      step();
    end
    rx_valid   = 1'b0;
    load_abort = 1'b0;
    check("run_no_bytes", 32'(bytes_acc - base_b), 32'd0);
    check("run_idle", 32'(load_busy), 32'd0);
    fetch_addr = 14'h2aaa;

    // Normal two-word load
    pay_q  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    base_w = wq_addr.size();
    run_load("normal", 2, 0);
    ws = wq_addr.size();
    if (ws >= base_w + 2) begin
      check("normal_word0", wq_data[base_w], 32'h12345678);
      check("normal_word1", wq_data[base_w + 1], 32'hDEADBEEF);
    end else begin
      check("normal_count", 32'(ws - base_w), 32'd2);
    end

    // Oversize header, sticky error, then zero header clears it
    pay_q.delete();
    run_load("oversize", 16'h4001, 0);
    repeat (3) step();
    check("oversize_sticky", 32'(load_err), 32'd1);
    run_load("zero", 0, 0);

    // Aborts: mid-word and coincident with a write
    fill_random(6);
    run_load("abort_byte", 3, 1);
    fill_random(8);
    run_load("abort_write", 3, 2);

    // Reset in the middle of a load
    base_w   = wq_addr.size();
    base_r   = rst_cycles;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    send_byte(8'd3);
    send_byte(8'd0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    check("midrst_pre_words", 32'(words_loaded), 32'd1);
    check("midrst_pre_busy", 32'(load_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(load_busy), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'(fetch_addr));
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    repeat (6) step();
    check("midrst_no_pulse", 32'(rst_cycles - base_r), 32'd0);
    check("midrst_writes", 32'(wq_addr.size() - base_w), 32'd1);

    // Randomized loads
    for (int r = 0; r < 6; r++) begin
      cnt  = $urandom_range(1, 4);
      kind = $urandom_range(0, 2);
      if (kind == 0)      npay = 4 * cnt;
      else if (kind == 1) npay = 4 * $urandom_range(0, cnt - 1) + $urandom_range(1, 3);
      else                npay = 4 * $urandom_range(1, cnt);
      fill_random(npay);
      run_load("rand", cnt, kind);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
